// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard: ID claims destinations, WB writes and releases.
// Define REGFILE_BYPASS_EN to forward same-cycle WB data and readiness to the read ports.
module regfile_scoreboard #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       rd1_addr,
  input  logic [ADDR_W-1:0]       rd2_addr,
  output logic [DATA_W-1:0]       rd1_data,
  output logic [DATA_W-1:0]       rd2_data,
  output logic                    rd1_busy,
  output logic                    rd2_busy,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_dst,
  output logic                    iss_ready,
  input  logic                    wb_valid,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    flush,
  output logic [(1<<ADDR_W)-1:0]  busy_vec,
  output logic                    err_wb
);
  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREGS-1:0]             busy_q, busy_d;
  logic                         err_q, err_d;
  logic                         iss_zero, wb_en, claim;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign iss_zero  = is_zero(iss_dst);
  assign wb_en     = wb_valid & ~is_zero(wb_addr);
  // A WB to the same register in the same cycle frees it for the new claim.
  assign iss_ready = ~flush & (iss_zero | ~busy_q[iss_dst] | (wb_valid & (wb_addr == iss_dst)));
  assign claim     = iss_valid & iss_ready & ~iss_zero;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    err_d  = err_q;
    if (wb_en) begin
      regs_d[wb_addr] = wb_data;
      busy_d[wb_addr] = 1'b0;
      if (!flush && !busy_q[wb_addr]) err_d = 1'b1;
    end
    // Set after clear so a same-cycle claim keeps the register busy.
    if (claim) busy_d[iss_dst] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    rd1_data = regs_q[rd1_addr];
    rd1_busy = busy_q[rd1_addr];
    rd2_data = regs_q[rd2_addr];
    rd2_busy = busy_q[rd2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && (wb_addr == rd1_addr)) begin
      rd1_data = wb_data;
      rd1_busy = 1'b0;
    end
    if (wb_valid && (wb_addr == rd2_addr)) begin
      rd2_data = wb_data;
      rd2_busy = 1'b0;
    end
`endif
    if (is_zero(rd1_addr)) begin
      rd1_data = '0;
      rd1_busy = 1'b0;
    end
    if (is_zero(rd2_addr)) begin
      rd2_data = '0;
      rd2_busy = 1'b0;
    end
  end

  assign busy_vec = busy_q;
  assign err_wb   = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (ZERO_REG=0 and 1) driven in lockstep, checked
// by directed scenarios and a random run against an array-based reference model.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, iss_valid, wb_valid, flush;
  logic [1:0] rd1_addr, rd2_addr, iss_dst, wb_addr;
  logic [7:0] wb_data;
  logic [1:0][7:0] rd1_data, rd2_data;
  logic [1:0]      rd1_busy, rd2_busy, iss_ready, err_wb;
  logic [1:0][3:0] busy_vec;

  int checks = 0;
  int failures = 0;

  regfile_scoreboard #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data[0]), .rd2_data(rd2_data[0]), .rd1_busy(rd1_busy[0]), .rd2_busy(rd2_busy[0]),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready[0]),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .busy_vec(busy_vec[0]), .err_wb(err_wb[0]));

  regfile_scoreboard #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data[1]), .rd2_data(rd2_data[1]), .rd1_busy(rd1_busy[1]), .rd2_busy(rd2_busy[1]),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready[1]),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .busy_vec(busy_vec[1]), .err_wb(err_wb[1]));

  // Reference model: index 0 plain, index 1 has a hardwired-zero r0.
  logic [7:0] m_regs [2][4];
  logic [3:0] m_busy [2];
  logic       m_err  [2];

  function automatic logic m_zero(int k, logic [1:0] a);
    return (k == 1) && (a == 2'd0);
  endfunction

  function automatic logic [7:0] exp_rd(int k, logic [1:0] a);
    if (m_zero(k, a)) return 8'h00;
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && wb_addr == a) return wb_data;
`endif
    return m_regs[k][a];
  endfunction

  function automatic logic exp_busy(int k, logic [1:0] a);
    if (m_zero(k, a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && wb_addr == a) return 1'b0;
`endif
    return m_busy[k][a];
  endfunction

  function automatic logic exp_ready(int k);
    return !flush && (m_zero(k, iss_dst) || !m_busy[k][iss_dst] || (wb_valid && wb_addr == iss_dst));
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] nb;
    logic       ne;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int j = 0; j < 4; j++) m_regs[k][j] <= 8'h00;
        m_busy[k] <= 4'h0;
        m_err[k]  <= 1'b0;
      end else begin
        nb = m_busy[k];
        ne = m_err[k];
        if (wb_valid && !m_zero(k, wb_addr)) begin
          m_regs[k][wb_addr] <= wb_data;
          if (!flush && !m_busy[k][wb_addr]) ne = 1'b1;
          nb[wb_addr] = 1'b0;
        end
        if (iss_valid && exp_ready(k) && !m_zero(k, iss_dst)) nb[iss_dst] = 1'b1;
        if (flush) nb = 4'h0;
        m_busy[k] <= nb;
        m_err[k]  <= ne;
      end
    end
  end

  task automatic drive(input logic r, input logic iv, input logic [1:0] id, input logic wv,
                       input logic [1:0] wa, input logic [7:0] wd, input logic fl,
                       input logic [1:0] a1, input logic [1:0] a2);
    @(negedge clk);
    rst = r; iss_valid = iv; iss_dst = id; wb_valid = wv; wb_addr = wa; wb_data = wd;
    flush = fl; rd1_addr = a1; rd2_addr = a2;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 8'h00, 0, 1, 1);
    drive(0, 0, 0, 1, 1, 8'h5A, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 8'h00, 0, 1, 1);
    checks++; if (rd1_data[0] !== 8'h5A) begin failures++; $display("FAIL reset_preload got=%h exp=5a", rd1_data[0]); end
    drive(1, 0, 0, 0, 0, 8'h00, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 8'h00, 0, 1, 1);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rd1_data[k] !== 8'h00) begin failures++; $display("FAIL reset_data[%0d] got=%h exp=00", k, rd1_data[k]); end
      checks++; if (busy_vec[k] !== 4'h0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0000", k, busy_vec[k]); end
      checks++; if (err_wb[k] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d] got=%b exp=0", k, err_wb[k]); end
    end
  endtask

  task automatic test_claim_release();
    drive(0, 1, 2, 0, 0, 8'h00, 0, 2, 2);
    checks++; if (iss_ready[0] !== 1'b1) begin failures++; $display("FAIL claim_ready got=%b exp=1", iss_ready[0]); end
    drive(0, 0, 0, 0, 0, 8'h00, 0, 2, 2);
    checks++; if (busy_vec[0] !== 4'b0100) begin failures++; $display("FAIL claim_vec got=%b exp=0100", busy_vec[0]); end
    checks++; if (rd1_busy[0] !== 1'b1 || rd2_busy[0] !== 1'b1) begin failures++; $display("FAIL claim_rdbusy got=%b%b exp=11", rd1_busy[0], rd2_busy[0]); end
    drive(0, 0, 0, 1, 2, 8'h33, 0, 2, 0);
`ifdef REGFILE_BYPASS_EN
    checks++; if (rd1_data[0] !== 8'h33 || rd1_busy[0] !== 1'b0) begin failures++; $display("FAIL bypass got=%h/%b exp=33/0", rd1_data[0], rd1_busy[0]); end
`else
    checks++; if (rd1_data[0] !== 8'h00 || rd1_busy[0] !== 1'b1) begin failures++; $display("FAIL no_bypass got=%h/%b exp=00/1", rd1_data[0], rd1_busy[0]); end
`endif
    drive(0, 0, 0, 0, 0, 8'h00, 0, 2, 0);
    checks++; if (rd1_data[0] !== 8'h33 || rd1_busy[0] !== 1'b0) begin failures++; $display("FAIL wb_release got=%h/%b exp=33/0", rd1_data[0], rd1_busy[0]); end
    checks++; if (err_wb[0] !== 1'b0) begin failures++; $display("FAIL wb_release_err got=%b exp=0", err_wb[0]); end
  endtask

  task automatic test_waw();
    drive(0, 1, 3, 0, 0, 8'h00, 0, 3, 0);
    checks++; if (iss_ready[0] !== 1'b1) begin failures++; $display("FAIL waw_first got=%b exp=1", iss_ready[0]); end
    drive(0, 1, 3, 0, 0, 8'h00, 0, 3, 0);
    checks++; if (iss_ready[0] !== 1'b0) begin failures++; $display("FAIL waw_stall got=%b exp=0", iss_ready[0]); end
    drive(0, 0, 0, 0, 0, 8'h00, 0, 3, 0);
    checks++; if (busy_vec[0] !== 4'b1000) begin failures++; $display("FAIL waw_vec got=%b exp=1000", busy_vec[0]); end
  endtask

  task automatic test_simultaneous();
    drive(0, 1, 3, 1, 3, 8'hC0, 0, 0, 0);
    checks++; if (iss_ready[0] !== 1'b1) begin failures++; $display("FAIL simul_ready got=%b exp=1", iss_ready[0]); end
    drive(0, 0, 0, 0, 0, 8'h00, 0, 3, 0);
    checks++; if (rd1_data[0] !== 8'hC0) begin failures++; $display("FAIL simul_data got=%h exp=c0", rd1_data[0]); end
    checks++; if (busy_vec[0] !== 4'b1000) begin failures++; $display("FAIL simul_vec got=%b exp=1000", busy_vec[0]); end
    checks++; if (err_wb[0] !== 1'b0) begin failures++; $display("FAIL simul_err got=%b exp=0", err_wb[0]); end
    drive(0, 0, 0, 1, 3, 8'hC0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    checks++; if (busy_vec[0] !== 4'b0000) begin failures++; $display("FAIL simul_release got=%b exp=0000", busy_vec[0]); end
  endtask

  task automatic test_flush();
    drive(0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    drive(0, 1, 2, 0, 0, 8'h00, 0, 0, 0);
    drive(0, 1, 3, 1, 1, 8'h77, 1, 1, 3);
    for (int k = 0; k < 2; k++) begin
      checks++; if (iss_ready[k] !== 1'b0) begin failures++; $display("FAIL flush_ready[%0d] got=%b exp=0", k, iss_ready[k]); end
    end
    drive(0, 0, 0, 0, 0, 8'h00, 0, 1, 3);
    for (int k = 0; k < 2; k++) begin
      checks++; if (busy_vec[k] !== 4'h0) begin failures++; $display("FAIL flush_vec[%0d] got=%b exp=0000", k, busy_vec[k]); end
      checks++; if (rd1_data[k] !== 8'h77) begin failures++; $display("FAIL flush_wb[%0d] got=%h exp=77", k, rd1_data[k]); end
    end
  endtask

  task automatic test_error();
    drive(0, 0, 0, 1, 2, 8'h11, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    checks++; if (err_wb[0] !== 1'b0) begin failures++; $display("FAIL err_flush_excl got=%b exp=0", err_wb[0]); end
    drive(0, 0, 0, 1, 1, 8'h11, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (err_wb[k] !== 1'b1) begin failures++; $display("FAIL err_set[%0d] got=%b exp=1", k, err_wb[k]); end
    end
    repeat (3) drive(0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    checks++; if (err_wb[0] !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err_wb[0]); end
    drive(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    checks++; if (err_wb[0] !== 1'b0) begin failures++; $display("FAIL err_rst got=%b exp=0", err_wb[0]); end
  endtask

  task automatic test_zero_reg();
    drive(0, 0, 0, 1, 0, 8'hFF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    checks++; if (rd1_data[1] !== 8'h00) begin failures++; $display("FAIL zero_read got=%h exp=00", rd1_data[1]); end
    checks++; if (err_wb[1] !== 1'b0) begin failures++; $display("FAIL zero_err got=%b exp=0", err_wb[1]); end
    checks++; if (rd1_data[0] !== 8'hFF || err_wb[0] !== 1'b1) begin failures++; $display("FAIL r0_plain got=%h/%b exp=ff/1", rd1_data[0], err_wb[0]); end
    drive(0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    checks++; if (iss_ready[1] !== 1'b1) begin failures++; $display("FAIL zero_claim_ready got=%b exp=1", iss_ready[1]); end
    drive(0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    checks++; if (busy_vec[1] !== 4'h0 || rd1_busy[1] !== 1'b0) begin failures++; $display("FAIL zero_claim_busy got=%b/%b exp=0000/0", busy_vec[1], rd1_busy[1]); end
    checks++; if (iss_ready[1] !== 1'b1 || iss_ready[0] !== 1'b0) begin failures++; $display("FAIL zero_reclaim got=%b%b exp=10", iss_ready[1], iss_ready[0]); end
    checks++; if (busy_vec[0] !== 4'b0001) begin failures++; $display("FAIL r0_claim_vec got=%b exp=0001", busy_vec[0]); end
    drive(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 2'($urandom), $urandom_range(0, 1),
            2'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0), 2'($urandom), 2'($urandom));
      if (rst) continue;
      for (int k = 0; k < 2; k++) begin
        checks++; if (rd1_data[k] !== exp_rd(k, rd1_addr)) begin failures++; $display("FAIL rnd_rd1[%0d] n=%0d got=%h exp=%h", k, n, rd1_data[k], exp_rd(k, rd1_addr)); end
        checks++; if (rd2_data[k] !== exp_rd(k, rd2_addr)) begin failures++; $display("FAIL rnd_rd2[%0d] n=%0d got=%h exp=%h", k, n, rd2_data[k], exp_rd(k, rd2_addr)); end
        checks++; if (rd1_busy[k] !== exp_busy(k, rd1_addr)) begin failures++; $display("FAIL rnd_b1[%0d] n=%0d got=%b exp=%b", k, n, rd1_busy[k], exp_busy(k, rd1_addr)); end
        checks++; if (rd2_busy[k] !== exp_busy(k, rd2_addr)) begin failures++; $display("FAIL rnd_b2[%0d] n=%0d got=%b exp=%b", k, n, rd2_busy[k], exp_busy(k, rd2_addr)); end
        checks++; if (iss_ready[k] !== exp_ready(k)) begin failures++; $display("FAIL rnd_ready[%0d] n=%0d got=%b exp=%b", k, n, iss_ready[k], exp_ready(k)); end
        checks++; if (busy_vec[k] !== m_busy[k]) begin failures++; $display("FAIL rnd_vec[%0d] n=%0d got=%b exp=%b", k, n, busy_vec[k], m_busy[k]); end
        checks++; if (err_wb[k] !== m_err[k]) begin failures++; $display("FAIL rnd_err[%0d] n=%0d got=%b exp=%b", k, n, err_wb[k], m_err[k]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; iss_valid = 1'b0; iss_dst = 2'd0; wb_valid = 1'b0; wb_addr = 2'd0;
    wb_data = 8'h00; flush = 1'b0; rd1_addr = 2'd0; rd2_addr = 2'd0;
    test_reset();
    test_claim_release();
    test_waw();
    test_simultaneous();
    test_flush();
    test_error();
    test_zero_reg();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
